block_compare_unit: RTL and testbench

Multi-cycle engine for the Z80 block-compare instructions CPI, CPD, CPIR and CPDR. It sits beside the control unit and acts as the initiator on the ALU interface. It fetches (HL) over a simple memory handshake, drives the ALU with `SUB8` (A − (HL)), captures the returned flags, updates HL and BC, and repeats when in repeat mode. On completion it hands back the updated HL, BC and the F register to the control unit.

---
 rtl/block_compare_unit.sv | 192 +++++++++++++++++++
 tb/tb_block_compare_unit.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/block_compare_unit.sv
// Z80 block-compare engine (CPI/CPD/CPIR/CPDR): reads (HL), compares against A via the ALU, steps HL/BC.
// Latency: 4 cycles start-to-done for one iteration with immediate ack; +3 cycles per repeat, +1 per ack wait.
// Backpressure: mem_req is held in READ until mem_ack; start is ignored whenever the engine is busy.

package alu_pkg;
   typedef enum logic [3:0] {
      ADD8 = 4'h0,
      SUB8 = 4'h1,
      AND8 = 4'h2,
      OR8  = 4'h3,
      XOR8 = 4'h4
   } alu_op;
endpackage

package cu_pkg;
   // Z80 F layout, bit 7 down to bit 0.
   typedef struct packed {
      logic s;
      logic z;
      logic f5;
      logic h;
      logic f3;
      logic v;
      logic n;
      logic c;
   } f_register;
endpackage

module block_compare_unit (
   input  logic                clk,
   input  logic                nrst,
   input  logic                start,
   input  logic [1:0]          mode,
   input  logic [7:0]          a_in,
   input  logic [15:0]         hl_in,
   input  logic [15:0]         bc_in,
   input  logic                c_in,
   input  logic                int_pending,
   output logic                mem_req,
   output logic [15:0]         mem_addr,
   input  logic                mem_ack,
   input  logic [7:0]          mem_rdata,
   output alu_pkg::alu_op      alu_op,
   output logic [15:0]         alu_x,
   output logic [15:0]         alu_y,
   output logic                alu_cin,
   input  cu_pkg::f_register   alu_flag,
   output logic [15:0]         hl_out,
   output logic [15:0]         bc_out,
   output cu_pkg::f_register   flag_out,
   output logic                busy,
   output logic                done
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      READ = 3'd1,
      CMP  = 3'd2,
      UPD  = 3'd3,
      DONE = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic [7:0]        a_q, a_d;
   logic [15:0]       hl_q, hl_d;
   logic [15:0]       bc_q, bc_d;
   logic              c_q, c_d;
   logic [1:0]        mode_q, mode_d;
   logic [7:0]        data_q, data_d;
   cu_pkg::f_register flag_q, flag_d;
   logic [15:0]       hl_out_q, hl_out_d;
   logic [15:0]       bc_out_q, bc_out_d;
   cu_pkg::f_register flag_out_q, flag_out_d;

   logic [15:0]       bc_dec;
   logic [15:0]       hl_step;
   logic              bc_nz;
   logic              unused_flag_bits;

   // Only S and Z come back from the ALU; the rest are rebuilt in UPD.
   assign unused_flag_bits = ^{alu_flag.f5, alu_flag.h, alu_flag.f3,
                               alu_flag.v, alu_flag.n, alu_flag.c};

   assign bc_dec  = bc_q - 16'd1;
   assign hl_step = mode_q[0] ? (hl_q - 16'd1) : (hl_q + 16'd1);
   assign bc_nz   = (bc_dec != 16'd0);

   // Next-state and datapath updates; results are loaded on the way into DONE so they are valid with done.
   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      hl_d       = hl_q;
      bc_d       = bc_q;
      c_d        = c_q;
      mode_d     = mode_q;
      data_d     = data_q;
      flag_d     = flag_q;
      hl_out_d   = hl_out_q;
      bc_out_d   = bc_out_q;
      flag_out_d = flag_out_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = a_in;
               hl_d    = hl_in;
               bc_d    = bc_in;
               c_d     = c_in;
               mode_d  = mode;
               state_d = READ;
            end
         end
         READ: begin
            if (mem_ack) begin
               data_d  = mem_rdata;
               state_d = CMP;
            end
         end
         CMP: begin
            flag_d.s = alu_flag.s;
            flag_d.z = alu_flag.z;
            state_d  = UPD;
         end
         UPD: begin
            hl_d      = hl_step;
            bc_d      = bc_dec;
            flag_d.f5 = 1'b0;
            flag_d.h  = 1'b0;
            flag_d.f3 = 1'b0;
            flag_d.v  = bc_nz;
            flag_d.n  = 1'b1;
            flag_d.c  = c_q;
            // Interrupts are only honoured here so an in-flight iteration always finishes.
            if (mode_q[1] && bc_nz && !flag_q.z && !int_pending) begin
               state_d = READ;
            end else begin
               hl_out_d   = hl_step;
               bc_out_d   = bc_dec;
               flag_out_d = flag_d;
               state_d    = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset abandons any pending read.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q    <= IDLE;
         a_q        <= 8'h00;
         hl_q       <= 16'h0000;
         bc_q       <= 16'h0000;
         c_q        <= 1'b0;
         mode_q     <= 2'b00;
         data_q     <= 8'h00;
         flag_q     <= '0;
         hl_out_q   <= 16'h0000;
         bc_out_q   <= 16'h0000;
         flag_out_q <= '0;
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         hl_q       <= hl_d;
         bc_q       <= bc_d;
         c_q        <= c_d;
         mode_q     <= mode_d;
         data_q     <= data_d;
         flag_q     <= flag_d;
         hl_out_q   <= hl_out_d;
         bc_out_q   <= bc_out_d;
         flag_out_q <= flag_out_d;
      end
   end

   assign mem_req  = (state_q == READ);
   assign mem_addr = hl_q;
   assign alu_op   = alu_pkg::SUB8;
   assign alu_x    = {8'h00, a_q};
   assign alu_y    = {8'h00, data_q};
   assign alu_cin  = 1'b0;
   assign hl_out   = hl_out_q;
   assign bc_out   = bc_out_q;
   assign flag_out = flag_out_q;
   assign busy     = (state_q != IDLE);
   assign done     = (state_q == DONE);

endmodule

// File: tb/tb_block_compare_unit.sv
// Bench for block_compare_unit: memory responder with programmable ack delay, behavioural ALU,
// and a scoreboard of expected HL/BC/F/latency pushed at start and popped on done.
// Covers single/repeat/decrement, wraps, interrupt exit, ack stalls, busy-start and mid-read reset.

module tb_block_compare_unit;

   typedef struct {
      logic [15:0] hl;
      logic [15:0] bc;
      logic [7:0]  f;
      int          cycles;
      int          iters;
   } exp_t;

   logic              clk = 1'b0;
   logic              nrst;
   logic              start;
   logic [1:0]        mode;
   logic [7:0]        a_in;
   logic [15:0]       hl_in;
   logic [15:0]       bc_in;
   logic              c_in;
   logic              int_pending;
   logic              mem_req;
   logic [15:0]       mem_addr;
   logic              mem_ack;
   logic [7:0]        mem_rdata;
   alu_pkg::alu_op    alu_op;
   logic [15:0]       alu_x;
   logic [15:0]       alu_y;
   logic              alu_cin;
   cu_pkg::f_register alu_flag;
   logic [15:0]       hl_out;
   logic [15:0]       bc_out;
   cu_pkg::f_register flag_out;
   logic              busy;
   logic              done;

   logic [7:0]  mem [0:65535];
   logic [7:0]  alu_diff;
   exp_t        sb [$];
   logic [15:0] addr_q [$];
   int          vectors = 0;
   int          miscompares = 0;
   int          ack_delay = 0;
   int          wcnt = 0;
   int          hs_cnt = 0;
   int          req_cyc = 0;

   always #5 clk = ~clk;

   block_compare_unit dut (
      .clk         (clk),
      .nrst        (nrst),
      .start       (start),
      .mode        (mode),
      .a_in        (a_in),
      .hl_in       (hl_in),
      .bc_in       (bc_in),
      .c_in        (c_in),
      .int_pending (int_pending),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_ack     (mem_ack),
      .mem_rdata   (mem_rdata),
      .alu_op      (alu_op),
      .alu_x       (alu_x),
      .alu_y       (alu_y),
      .alu_cin     (alu_cin),
      .alu_flag    (alu_flag),
      .hl_out      (hl_out),
      .bc_out      (bc_out),
      .flag_out    (flag_out),
      .busy        (busy),
      .done        (done)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Behavioural 8-bit subtract ALU.
   always_comb begin
      alu_diff   = alu_x[7:0] - alu_y[7:0];
      alu_flag   = '0;
      alu_flag.s = alu_diff[7];
      alu_flag.z = (alu_diff == 8'h00);
   end

   // Memory responder: acks after ack_delay wait cycles, checks read order.
   always @(negedge clk) begin
      if (mem_req) begin
         req_cyc++;
         if (wcnt == ack_delay) begin
            mem_ack   = 1'b1;
            mem_rdata = mem[mem_addr];
            hs_cnt++;
            if (addr_q.size() > 0) chk("rd_addr", {16'h0, mem_addr}, {16'h0, addr_q.pop_front()});
            wcnt = 0;
         end else begin
            mem_ack = 1'b0;
            wcnt++;
         end
      end else begin
         mem_ack = 1'b0;
         wcnt    = 0;
      end
   end

   task automatic model(input logic [7:0] a, input logic [15:0] hl, input logic [15:0] bc,
                        input logic c, input logic [1:0] md, input int dly, input logic intp,
                        output exp_t e);
      logic [15:0] h;
      logic [15:0] b;
      logic [7:0]  d;
      logic        z, s, v;
      int          it;
      h  = hl;
      b  = bc;
      it = 0;
      do begin
         addr_q.push_back(h);
         d = a - mem[h];
         z = (d == 8'h00);
         s = d[7];
         h = md[0] ? h - 16'd1 : h + 16'd1;
         b = b - 16'd1;
         v = (b != 16'h0000);
         it++;
      end while (md[1] && v && !z && !intp);
      e.hl     = h;
      e.bc     = b;
      e.f      = {s, z, 1'b0, 1'b0, 1'b0, v, 1'b1, c};
      e.iters  = it;
      e.cycles = 1 + it * (3 + dly);
   endtask

   task automatic run(input logic [7:0] a, input logic [15:0] hl, input logic [15:0] bc,
                      input logic c, input logic [1:0] md, input int dly, input logic intp,
                      input logic noise);
      exp_t e;
      int   n;
      bit   seen;
      model(a, hl, bc, c, md, dly, intp, e);
      sb.push_back(e);
      ack_delay = dly;
      hs_cnt    = 0;
      req_cyc   = 0;
      @(negedge clk);
      start = 1'b1; a_in = a; hl_in = hl; bc_in = bc; c_in = c; mode = md; int_pending = intp;
      n    = 0;
      seen = 0;
      while (!seen && n < 2000) begin
         @(negedge clk);
         n++;
         start = 1'b0;
         if (noise && n == 2) begin
            start = 1'b1; a_in = ~a; hl_in = ~hl; bc_in = 16'h0001; c_in = ~c; mode = ~md;
         end
         if (n == 1) chk("busy_rise", {31'h0, busy}, 32'h1);
         if (done) seen = 1;
      end
      if (!seen) begin
         chk("done_timeout", 32'h0, 32'h1);
         void'(sb.pop_front());
         addr_q.delete();
         int_pending = 1'b0;
         return;
      end
      e = sb.pop_front();
      chk("done_cycle", n, e.cycles);
      chk("hl_out", {16'h0, hl_out}, {16'h0, e.hl});
      chk("bc_out", {16'h0, bc_out}, {16'h0, e.bc});
      chk("flag_out", {24'h0, flag_out}, {24'h0, e.f});
      chk("handshakes", hs_cnt, e.iters);
      chk("req_cycles", req_cyc, e.iters * (dly + 1));
      @(negedge clk);
      start = 1'b0;
      int_pending = 1'b0;
      chk("busy_fall", {31'h0, busy}, 32'h0);
      chk("done_pulse", {31'h0, done}, 32'h0);
      chk("hl_hold", {16'h0, hl_out}, {16'h0, e.hl});
      chk("flag_hold", {24'h0, flag_out}, {24'h0, e.f});
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_req"},  {31'h0, mem_req}, 32'h0);
      chk({tag, "_busy"}, {31'h0, busy}, 32'h0);
      chk({tag, "_done"}, {31'h0, done}, 32'h0);
      chk({tag, "_hl"},   {16'h0, hl_out}, 32'h0);
      chk({tag, "_bc"},   {16'h0, bc_out}, 32'h0);
      chk({tag, "_f"},    {24'h0, flag_out}, 32'h0);
      chk({tag, "_addr"}, {16'h0, mem_addr}, 32'h0);
   endtask

   initial begin
      int   n;
      logic [15:0] h;
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
      nrst = 1'b0; start = 1'b0; mode = 2'b00; a_in = 8'h00; hl_in = 16'h0; bc_in = 16'h0;
      c_in = 1'b0; int_pending = 1'b0; mem_ack = 1'b0; mem_rdata = 8'h00;
      #12;
      chk_zero("reset");
      @(negedge clk);
      nrst = 1'b1;

      // CPI single match
      mem[16'h1000] = 8'h42;
      run(8'h42, 16'h1000, 16'h0001, 1'b1, 2'b00, 0, 1'b0, 1'b0);

      // CPIR hit on third byte, with a start pulse while busy
      mem[16'h2000] = 8'h00; mem[16'h2001] = 8'h10; mem[16'h2002] = 8'h7F;
      run(8'h7F, 16'h2000, 16'h0010, 1'b0, 2'b10, 0, 1'b0, 1'b1);

      // CPDR exhaust through HL wrap, no match
      mem[16'h0001] = 8'h11; mem[16'h0000] = 8'h22; mem[16'hFFFF] = 8'h33;
      run(8'h99, 16'h0001, 16'h0003, 1'b1, 2'b11, 0, 1'b0, 1'b0);

      // BC = 0 wrap: CPI, then CPIR matching on first byte
      mem[16'h3000] = 8'h01;
      run(8'h05, 16'h3000, 16'h0000, 1'b0, 2'b00, 0, 1'b0, 1'b0);
      mem[16'h3000] = 8'h05;
      run(8'h05, 16'h3000, 16'h0000, 1'b1, 2'b10, 0, 1'b0, 1'b0);

      // Interrupt ends CPIR after one iteration; ack stalled two cycles
      for (int i = 0; i < 8; i++) mem[16'h4000 + i] = 8'hA0;
      run(8'h01, 16'h4000, 16'h0005, 1'b1, 2'b10, 2, 1'b1, 1'b0);

      // Random short loops
      for (int k = 0; k < 4; k++) begin
         h = 16'h6000 + 16'(k * 32);
         for (int i = -8; i < 8; i++) mem[h + 16'(i)] = 8'($urandom_range(0, 7));
         run(8'($urandom_range(0, 7)), h, 16'($urandom_range(1, 6)), 1'($urandom_range(0, 1)),
             2'($urandom_range(0, 3)), $urandom_range(0, 2), 1'b0, 1'b0);
      end

      // Reset while a read is outstanding
      ack_delay = 5;
      @(negedge clk);
      start = 1'b1; a_in = 8'h55; hl_in = 16'h5000; bc_in = 16'h0004; mode = 2'b10; c_in = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (!mem_req && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("req_before_reset", {31'h0, mem_req}, 32'h1);
      @(negedge clk);
      #2 nrst = 1'b0;
      #1 chk_zero("midread");
      @(negedge clk);
      nrst = 1'b1;
      mem[16'h5000] = 8'h55;
      run(8'h55, 16'h5000, 16'h0004, 1'b1, 2'b10, 0, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
